// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - pushbutton/switch conditioner for the 128-bit entry register
//
// Synchronizes the raw pushbuttons and byte switches, debounces each button,
// and turns accepted presses into registered single-cycle strobes
// (capture_key, left_shift, right_shift) plus a start level that toggles on
// every accepted start press.
//
// Optional feature: define BTN_AUTOREPEAT_EN to add hold-to-repeat on the
// left/right buttons (first repeat REPEAT_DELAY cycles after the press pulse,
// then every REPEAT_PERIOD cycles until release).
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   btn_capture  in   raw async pushbutton, high = pressed
//   btn_left     in   raw async pushbutton
//   btn_right    in   raw async pushbutton
//   btn_start    in   raw async pushbutton
//   sw_in[7:0]   in   raw async byte switches
//   capture_key  out  one-cycle pulse per accepted capture press
//   left_shift   out  one-cycle pulse per accepted left press (or repeat)
//   right_shift  out  one-cycle pulse per accepted right press (or repeat)
//   start        out  level toggling on each accepted start press
//   d_in[7:0]    out  synchronized switch byte (not debounced)

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_capture,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_start,
    input  logic [7:0] sw_in,
    output logic       capture_key,
    output logic       left_shift,
    output logic       right_shift,
    output logic       start,
    output logic [7:0] d_in
);

    localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CNT = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button bit order: 0 capture, 1 left, 2 right, 3 start.
    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       stable;
    logic [3:0]       stable_d;
    logic [3:0]       evt;
    logic [3:0]       rep_hit;
    logic [CNT_W-1:0] db_cnt [4];
    logic [7:0]       sw_s1;
    logic [7:0]       sw_s2;

    assign raw  = {btn_start, btn_right, btn_left, btn_capture};
    assign d_in = sw_s2;

    // Synchronizers and per-button debounce.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sw_s1 <= '0;
            sw_s2 <= '0;
            stable <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            sw_s1 <= sw_in;
            sw_s2 <= sw_s1;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    // Repeat timers for left (index 0) and right (index 1). Each counts the
    // cycles the stable level has been high; phase 0 waits REPEAT_DELAY,
    // phase 1 waits REPEAT_PERIOD between subsequent repeats.
    logic [CNT_W-1:0] rep_cnt [2];
    logic [1:0]       rep_phase;
    logic [1:0]       rep_fire;

    always_comb begin
        rep_fire = '0;
        for (int k = 0; k < 2; k++) begin
            if (stable[k+1]) begin
                if (rep_phase[k]) begin
                    rep_fire[k] = (rep_cnt[k] == CNT_W'(REPEAT_PERIOD));
                end else begin
                    rep_fire[k] = (rep_cnt[k] == CNT_W'(REPEAT_DELAY));
                end
            end
        end
    end

    assign rep_hit = {1'b0, rep_fire, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_phase <= '0;
            for (int k = 0; k < 2; k++) begin
                rep_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!stable[k+1]) begin
                    rep_cnt[k]   <= '0;
                    rep_phase[k] <= 1'b0;
                end else if (rep_fire[k]) begin
                    rep_cnt[k]   <= CNT_W'(1);
                    rep_phase[k] <= 1'b1;
                end else begin
                    rep_cnt[k] <= rep_cnt[k] + 1'b1;
                end
            end
        end
    end
`else
    assign rep_hit = '0;
`endif

    // Event stage (press edges plus repeats) followed by the registered
    // output stage, which applies lockout and capture > left > right priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_d    <= '0;
            evt         <= '0;
            capture_key <= 1'b0;
            left_shift  <= 1'b0;
            right_shift <= 1'b0;
            start       <= 1'b0;
        end else begin
            stable_d    <= stable;
            evt         <= (stable & ~stable_d) | rep_hit;
            capture_key <= evt[0] & ~start;
            left_shift  <= evt[1] & ~evt[0] & ~start;
            right_shift <= evt[2] & ~evt[1] & ~evt[0] & ~start;
            if (evt[3]) begin
                start <= ~start;
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard testbench for button_conditioner

module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_capture = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_start = 1'b0;
    logic [7:0] sw_in = 8'h00;
    logic       capture_key;
    logic       left_shift;
    logic       right_shift;
    logic       start;
    logic [7:0] d_in;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_capture(btn_capture),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .btn_start(btn_start),
        .sw_in(sw_in),
        .capture_key(capture_key),
        .left_shift(left_shift),
        .right_shift(right_shift),
        .start(start),
        .d_in(d_in)
    );

    always #5 clk = ~clk;

    // cyc holds the number of the next posedge; after edge E it reads E+1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   edge_n;
        int   kind;   // 0 capture, 1 left, 2 right, 3 start toggle
        logic val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic start_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int edge_n, input int kind, input logic val);
        exp_t e;
        e.edge_n = edge_n;
        e.kind   = kind;
        e.val    = val;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind, input logic val);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output got kind=%0d val=%0d edge=%0d expected none",
                     kind, val, cyc - 1);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.edge_n != cyc - 1 || e.val !== val) begin
                errors++;
                $display("FAIL output_event got kind=%0d val=%0d edge=%0d expected kind=%0d val=%0d edge=%0d",
                         kind, val, cyc - 1, e.kind, e.val, e.edge_n);
            end
        end
    endtask

    // Monitor: every strobe or start change is matched against the scoreboard.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (capture_key) observe(0, 1'b1);
            if (left_shift)  observe(1, 1'b1);
            if (right_shift) observe(2, 1'b1);
            if (start !== start_prev) observe(3, start);
            if (capture_key | left_shift | right_shift)
                chk("pulse_onehot", {29'd0, capture_key, left_shift, right_shift} & 32'h7,
                    capture_key ? 32'h4 : (left_shift ? 32'h2 : 32'h1));
        end
        start_prev = start;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press pulse after edge t0+7, plus auto-repeats while held when enabled.
    task automatic expect_lr(input int kind, input int t0, input int hold);
        push(t0 + 7, kind, 1'b1);
`ifdef BTN_AUTOREPEAT_EN
        for (int e = 17; e <= hold + 5; e += 5) push(t0 + e, kind, 1'b1);
`endif
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_capture"}, {31'd0, capture_key}, 0);
        chk({tag, "_left"},    {31'd0, left_shift},  0);
        chk({tag, "_right"},   {31'd0, right_shift}, 0);
        chk({tag, "_start"},   {31'd0, start},       0);
        chk({tag, "_d_in"},    {24'd0, d_in},        0);
    endtask

    initial begin
        int   t0;
        logic bounce [5];
        bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        step(3);
        chk_outputs_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;
        step(2);

        // Left held 30 cycles: pulse after edge 7, none on release.
        t0 = cyc;
        btn_left = 1'b1;
        expect_lr(1, t0, 30);
        step(30);
        btn_left = 1'b0;
        step(20);

        // Capture bounce is rejected; steady press from edge 20 pulses after 27.
        t0 = cyc;
        for (int i = 0; i < 5; i++) begin
            btn_capture = bounce[i];
            step(1);
        end
        btn_capture = 1'b0;
        step(15);
        btn_capture = 1'b1;
        push(t0 + 27, 0, 1'b1);
        step(12);
        btn_capture = 1'b0;
        step(15);

        // Start toggles; capture locked out while start is high.
        t0 = cyc;
        btn_start = 1'b1;
        push(t0 + 7, 3, 1'b1);
        step(10);
        btn_start = 1'b0;
        step(12);
        chk("start_on", {31'd0, start}, 1);
        btn_capture = 1'b1;
        step(10);
        btn_capture = 1'b0;
        step(12);
        chk("start_still_on", {31'd0, start}, 1);
        t0 = cyc;
        btn_start = 1'b1;
        push(t0 + 7, 3, 1'b0);
        step(10);
        btn_start = 1'b0;
        step(12);
        chk("start_off", {31'd0, start}, 0);

        // Simultaneous capture and right: only capture pulses.
        t0 = cyc;
        btn_capture = 1'b1;
        btn_right = 1'b1;
        push(t0 + 7, 0, 1'b1);
        step(10);
        btn_capture = 1'b0;
        btn_right = 1'b0;
        step(12);

        // Switch sync latency.
        sw_in = 8'hA5;
        step(1);
        chk("d_in_after_1", {24'd0, d_in}, 32'h00);
        step(1);
        chk("d_in_after_2", {24'd0, d_in}, 32'hA5);

        // Reset mid-debounce, then re-qualification of the held button.
        btn_left = 1'b1;
        step(3);
        rst = 1'b1;
        step(2);
        chk_outputs_zero("midreset");
        rst = 1'b0;
        t0 = cyc;
        expect_lr(1, t0, 10);
        step(10);
        btn_left = 1'b0;
        step(15);

        // Right held 40 cycles (repeats when enabled).
        t0 = cyc;
        btn_right = 1'b1;
        expect_lr(2, t0, 40);
        step(40);
        btn_right = 1'b0;
        step(20);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end stage that turns the board's raw pushbuttons and byte switches into the clean control strobes consumed by the 128-bit message/key entry register. It synchronizes asynchronous inputs, debounces each button, and emits single-cycle capture/left/right pulses plus a latched start level. It also applies the priority and lockout rules the entry register expects.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a button level change; minimum 2.
- REPEAT_DELAY, 25000000, hold cycles before the first auto-repeat pulse; used only with the macro.
- REPEAT_PERIOD, 5000000, cycles between later auto-repeat pulses; used only with the macro.
- Counter widths are $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1).

- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- btn_capture  in  1  raw async pushbutton, high = pressed
- btn_left  in  1  raw async pushbutton
- btn_right  in  1  raw async pushbutton
- btn_start  in  1  raw async pushbutton
- sw_in  in  8  raw async byte switches
- capture_key  out  1  one-cycle pulse per accepted capture press
- left_shift  out  1  one-cycle pulse per accepted left press
- right_shift  out  1  one-cycle pulse per accepted right press
- start  out  1  level that toggles on each accepted start press
- d_in  out  8  synchronized switch byte

## Operation
- **Synchronization:** each button and each sw_in bit passes through a 2-flop synchronizer. d_in is the second flop, so no debounce is applied to the switches.
- **Debounce, per button:** the block keeps a stable level and a counter.
  - While the synchronized sample equals the stable level, the counter is held at 0.
  - While the sample differs, the counter increments.
  - If the sample reverts before the count completes, the counter clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the sample still differs, the stable level flips on that edge and the counter clears.
- **Press event:** a 0→1 transition of a stable level. Release (1→0) is debounced the same way but produces no output.
- **start:** toggles on each btn_start press event.
- **Lockout:** while start==1, capture_key, left_shift and right_shift are forced to 0. Their debouncers keep running, and suppressed events are discarded, not queued.
- **Priority:** if more than one press event lands in the same cycle, only one pulse is emitted, in the order capture > left > right. Lower-priority events are dropped.
- **Registered outputs:** all pulses are registered and never exceed one cycle per event.
- **Reset:** rst clears synchronizers, stable levels, counters and all outputs to 0 (start=0, d_in=0). Reset mid-count discards any partial debounce. A button still held after rst deasserts must be re-qualified for DEBOUNCE_CYCLES and then produces a press event.

## Timing
- Latency: the first posedge sampling a raw button high is edge 0. With the raw level held steady, the pulse (or start toggle) is visible after edge DEBOUNCE_CYCLES+3 and lasts exactly one cycle.
- d_in follows sw_in 2 edges later.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no output.
- There is no minimum spacing between press events beyond two full debounce intervals (press, then release).

## Configuration
- **Macro BTN_AUTOREPEAT_EN defined:** while the left or right stable level remains 1, a repeat counter runs. An extra pulse is emitted REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles until release.
  - Repeats obey lockout and priority.
  - Release or rst clears the repeat counter immediately.
  - Capture and start never repeat.
- **Macro not defined:** exactly one pulse per press, regardless of hold time. No repeat counters are synthesized.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.

1. btn_left held high from edge 0 for 30 cycles → left_shift high for one cycle after edge 7 only (no macro); no pulse on release.
2. btn_capture bounces 1,0,1,1,0 then held high from edge 20 → no pulse during the bounce; a single capture_key pulse after edge 27.
3. btn_start pressed and released twice → start 0→1 after the first press, 1→0 after the second. During start=1, a btn_capture press yields no capture_key.
4. btn_capture and btn_right rise on the same edge → capture_key pulses once; right_shift stays 0 throughout.
5. sw_in=8'hA5 applied → d_in=8'hA5 after 2 edges. rst asserted mid-debounce of btn_left → no pulse; outputs 0; after rst drops with the button still held, left_shift pulses after DEBOUNCE_CYCLES+3 edges.
6. BTN_AUTOREPEAT_EN defined, btn_right held for 40 cycles → pulses after edges 7, 17, 22, 27, 32, 37, …; none after release.
